// File: rtl/riscv_exec_pkg.sv
// Shared constants for the RV32I combined decode/execute/data-memory stage.
// Opcodes, ALU op codes, next-PC select codes and funct3 encodings.
package riscv_exec_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JALR   = 2'b10;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU,
        ALU_PASS_B
    } alu_op_e;

    // SUB only exists for R-type; the immediate form of 000 is always ADD.
    function automatic alu_op_e alu_dec(
        input logic [2:0] f3,
        input logic       f7b5,
        input logic       is_r
    );
        alu_op_e op;
        unique case (f3)
            3'b000:  op = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/riscv_exec_mem_unit_dmem.sv
// Data memory: async-cleared word array, combinational read.
// Byte/halfword lanes and load extension only when SUBWORD_MEM_EN is defined.
module exec_dmem
    import riscv_exec_pkg::*;
#(
    parameter int WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_we,
    input  logic        i_re,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_rdata
);

    localparam int AW = $clog2(WORDS);

    logic [31:0]   r_mem [WORDS];
    logic [AW-1:0] w_idx;
    logic [31:0]   w_word;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic [31:0]   w_ld;
    logic          w_unused;

    assign w_idx  = i_addr[AW+1:2];
    assign w_word = r_mem[w_idx];

`ifdef SUBWORD_MEM_EN
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_shift;

    assign w_shift  = w_word >> {i_addr[1:0], 3'b000};
    assign w_byte   = w_shift[7:0];
    assign w_half   = i_addr[1] ? w_word[31:16] : w_word[15:0];
    assign w_unused = ^{i_addr[31:AW+2], w_shift[31:8]};

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = i_wdata;
        unique case (i_funct3[1:0])
            F3_SB[1:0]: begin
                w_be    = 4'b0001 << i_addr[1:0];
                w_wdata = {4{i_wdata[7:0]}};
            end
            F3_SH[1:0]: begin
                w_be    = i_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{i_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_ld = w_word;
        unique case (i_funct3)
            F3_LB:   w_ld = {{24{w_byte[7]}}, w_byte};
            F3_LH:   w_ld = {{16{w_half[15]}}, w_half};
            F3_LBU:  w_ld = {24'd0, w_byte};
            F3_LHU:  w_ld = {16'd0, w_half};
            default: w_ld = w_word;
        endcase
    end
`else
    assign w_be     = 4'b1111;
    assign w_wdata  = i_wdata;
    assign w_ld     = w_word;
    assign w_unused = ^{i_addr[31:AW+2], i_addr[1:0], i_funct3};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WORDS; i++) r_mem[i] <= '0;
        end else if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
            end
        end
    end

    assign o_rdata = i_re ? w_ld : '0;

endmodule

// File: rtl/riscv_exec_mem_unit.sv
// Single-cycle RV32I decode + execute + data memory; optional SUBWORD_MEM_EN
// enables byte/halfword loads and stores in the data memory.
module riscv_exec_mem_unit
    import riscv_exec_pkg::*;
#(
    parameter int DMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] imm,
    output logic        reg_write,
    output logic [1:0]  pc_src,
    output logic [31:0] alu_result,
    output logic        zero,
    output logic [31:0] wb_data
);

    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic        w_f7b5;
    logic        w_rw;
    logic        w_mr;
    logic        w_mw;
    logic        w_jump;
    logic        w_taken;
    logic [1:0]  w_pc_src;
    logic [31:0] w_a;
    logic [31:0] w_b;
    alu_op_e     w_op;
    logic [31:0] w_alu;
    logic [31:0] w_ld;
    logic        w_unused;

    assign w_opc    = instr[6:0];
    assign w_f3     = instr[14:12];
    assign w_f7b5   = instr[30];
    assign w_unused = ^{instr[31], instr[29:15], instr[11:7]};

    always_comb begin
        w_taken = 1'b0;
        unique case (w_f3)
            F3_BEQ:  w_taken = (rs1_data == rs2_data);
            F3_BNE:  w_taken = (rs1_data != rs2_data);
            F3_BLT:  w_taken = ($signed(rs1_data) < $signed(rs2_data));
            F3_BGE:  w_taken = ($signed(rs1_data) >= $signed(rs2_data));
            F3_BLTU: w_taken = (rs1_data < rs2_data);
            F3_BGEU: w_taken = (rs1_data >= rs2_data);
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_rw     = 1'b0;
        w_mr     = 1'b0;
        w_mw     = 1'b0;
        w_jump   = 1'b0;
        w_pc_src = PC_PLUS4;
        w_a      = rs1_data;
        w_b      = imm;
        w_op     = ALU_ADD;
        unique case (1'b1)
            (w_opc == OP_R): begin
                w_rw = 1'b1;
                w_b  = rs2_data;
                w_op = alu_dec(w_f3, w_f7b5, 1'b1);
            end
            (w_opc == OP_I): begin
                w_rw = 1'b1;
                w_op = alu_dec(w_f3, w_f7b5, 1'b0);
            end
            (w_opc == OP_LOAD): begin
                w_rw = 1'b1;
                w_mr = 1'b1;
            end
            (w_opc == OP_STORE): w_mw = 1'b1;
            (w_opc == OP_BRANCH): begin
                w_b      = rs2_data;
                w_op     = ALU_SUB;
                w_pc_src = w_taken ? PC_BRANCH : PC_PLUS4;
            end
            (w_opc == OP_JAL): begin
                w_rw     = 1'b1;
                w_jump   = 1'b1;
                w_a      = pc;
                w_pc_src = PC_BRANCH;
            end
            (w_opc == OP_JALR): begin
                w_rw     = 1'b1;
                w_jump   = 1'b1;
                w_pc_src = PC_JALR;
            end
            (w_opc == OP_LUI): begin
                w_rw = 1'b1;
                w_op = ALU_PASS_B;
            end
            (w_opc == OP_AUIPC): begin
                w_rw = 1'b1;
                w_a  = pc;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_alu = '0;
        unique case (w_op)
            ALU_ADD:    w_alu = w_a + w_b;
            ALU_SUB:    w_alu = w_a - w_b;
            ALU_AND:    w_alu = w_a & w_b;
            ALU_OR:     w_alu = w_a | w_b;
            ALU_XOR:    w_alu = w_a ^ w_b;
            ALU_SLL:    w_alu = w_a << w_b[4:0];
            ALU_SRL:    w_alu = w_a >> w_b[4:0];
            ALU_SRA:    w_alu = $unsigned($signed(w_a) >>> w_b[4:0]);
            ALU_SLT:    w_alu = {31'd0, $signed(w_a) < $signed(w_b)};
            ALU_SLTU:   w_alu = {31'd0, w_a < w_b};
            ALU_PASS_B: w_alu = w_b;
            default:    w_alu = '0;
        endcase
    end

    exec_dmem #(
        .WORDS(DMEM_WORDS)
    ) u_dmem (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_we     (w_mw),
        .i_re     (w_mr),
        .i_addr   (w_alu),
        .i_wdata  (rs2_data),
        .i_funct3 (w_f3),
        .o_rdata  (w_ld)
    );

    assign reg_write  = w_rw;
    assign pc_src     = w_pc_src;
    assign alu_result = w_alu;
    assign zero       = (w_alu == 32'd0);
    assign wb_data    = w_mr   ? w_ld :
                        w_jump ? pc + 32'd4 : w_alu;

endmodule

// File: tb/tb_riscv_exec_mem_unit.sv
// Table-driven bench for riscv_exec_mem_unit with a scoreboard queue and
// hand-written store/load, wrap and reset sequences.
module tb_riscv_exec_mem_unit;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic        rw;
        logic [1:0]  ps;
        logic [31:0] alu;
        logic [31:0] wb;
        logic        ca;
        logic        cw;
        logic        cz;
        logic        z;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = '0;
    logic [31:0] pc = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic [31:0] imm = '0;
    logic        reg_write;
    logic [1:0]  pc_src;
    logic [31:0] alu_result;
    logic        zero;
    logic [31:0] wb_data;

    int   checks = 0;
    int   errors = 0;
    vec_t sb[$];
    vec_t tbl[20];

    localparam logic [31:0] I_LW = 32'h0000A183;
    localparam logic [31:0] I_LB = 32'h00008183;
    localparam logic [31:0] I_SW = 32'h0020A823;

    riscv_exec_mem_unit #(.DMEM_WORDS(256)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .pc         (pc),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .imm        (imm),
        .reg_write  (reg_write),
        .pc_src     (pc_src),
        .alu_result (alu_result),
        .zero       (zero),
        .wb_data    (wb_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation ran past its time limit");
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(
        input logic [31:0] i, input logic [31:0] p,
        input logic [31:0] a, input logic [31:0] b,
        input logic [31:0] im, input logic rw, input logic [1:0] ps,
        input logic ca, input logic [31:0] alu,
        input logic cw, input logic [31:0] wb,
        input logic cz, input logic z
    );
        vec_t v;
        v.instr = i;  v.pc = p;   v.rs1 = a; v.rs2 = b; v.imm = im;
        v.rw    = rw; v.ps = ps;  v.ca = ca; v.alu = alu;
        v.cw    = cw; v.wb = wb;  v.cz = cz; v.z = z;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic apply(input string nm, input vec_t v);
        vec_t e;
        @(negedge clk);
        instr    = v.instr;
        pc       = v.pc;
        rs1_data = v.rs1;
        rs2_data = v.rs2;
        imm      = v.imm;
        sb.push_back(v);
        #1;
        e = sb.pop_front();
        chk({nm, ".reg_write"}, {31'd0, reg_write}, {31'd0, e.rw});
        chk({nm, ".pc_src"}, {30'd0, pc_src}, {30'd0, e.ps});
        if (e.ca) chk({nm, ".alu_result"}, alu_result, e.alu);
        if (e.cw) chk({nm, ".wb_data"}, wb_data, e.wb);
        if (e.cz) chk({nm, ".zero"}, {31'd0, zero}, {31'd0, e.z});
    endtask

    initial begin
        tbl[0]  = mk(32'h002081B3, 0, 5, 7, 0, 1, 2'b00, 1, 12, 1, 12, 1, 0);
        tbl[1]  = mk(32'h402081B3, 0, 7, 7, 0, 1, 2'b00, 1, 0, 1, 0, 1, 1);
        tbl[2]  = mk(32'h4040D193, 0, 32'h80000000, 0, 32'h404,
                     1, 2'b00, 1, 32'hF8000000, 1, 32'hF8000000, 1, 0);
        tbl[3]  = mk(32'h0020B1B3, 0, 32'hFFFFFFFF, 1, 0,
                     1, 2'b00, 1, 0, 1, 0, 1, 1);
        tbl[4]  = mk(32'h0020A1B3, 0, 32'hFFFFFFFF, 1, 0,
                     1, 2'b00, 1, 1, 1, 1, 0, 0);
        tbl[5]  = mk(32'h0020C1B3, 0, 32'hF0F0F0F0, 32'hFF00FF00, 0,
                     1, 2'b00, 1, 32'h0FF00FF0, 1, 32'h0FF00FF0, 0, 0);
        tbl[6]  = mk(32'h0020E1B3, 0, 32'h0000F000, 32'h0000000F, 0,
                     1, 2'b00, 1, 32'h0000F00F, 1, 32'h0000F00F, 0, 0);
        tbl[7]  = mk(32'h0020F1B3, 0, 32'h0000FF0F, 32'h00000FF0, 0,
                     1, 2'b00, 1, 32'h00000F00, 1, 32'h00000F00, 0, 0);
        tbl[8]  = mk(32'h002091B3, 0, 32'h00000003, 33, 0,
                     1, 2'b00, 1, 6, 1, 6, 0, 0);
        tbl[9]  = mk(32'h0020D1B3, 0, 32'h80000000, 4, 0,
                     1, 2'b00, 1, 32'h08000000, 1, 32'h08000000, 0, 0);
        tbl[10] = mk(32'h40008193, 0, 10, 0, 32'h00000400,
                     1, 2'b00, 1, 32'h0000040A, 1, 32'h0000040A, 0, 0);
        tbl[11] = mk(32'h00209463, 0, 1, 2, 8, 0, 2'b01, 0, 0, 0, 0, 0, 0);
        tbl[12] = mk(32'h0020D463, 0, 32'hFFFFFFFF, 0, 8,
                     0, 2'b00, 0, 0, 0, 0, 0, 0);
        tbl[13] = mk(32'h0020E463, 0, 1, 32'hFFFFFFFF, 8,
                     0, 2'b01, 0, 0, 0, 0, 0, 0);
        tbl[14] = mk(32'h00208463, 0, 9, 9, 8, 0, 2'b01, 0, 0, 0, 0, 1, 1);
        tbl[15] = mk(32'h0020A463, 0, 9, 9, 8, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        tbl[16] = mk(32'h000080E7, 32'h40, 32'h80, 0, 4,
                     1, 2'b10, 1, 32'h84, 1, 32'h44, 0, 0);
        tbl[17] = mk(32'h008000EF, 32'h100, 0, 0, 8,
                     1, 2'b01, 0, 0, 1, 32'h104, 0, 0);
        tbl[18] = mk(32'h123451B7, 0, 32'h55, 0, 32'h12345000,
                     1, 2'b00, 0, 0, 1, 32'h12345000, 0, 0);
        tbl[19] = mk(32'h00001197, 32'h200, 0, 0, 32'h1000,
                     1, 2'b00, 0, 0, 1, 32'h1200, 0, 0);

        instr = I_LW;
        #3;
        chk("reset_load", wb_data, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) apply($sformatf("vec%0d", i), tbl[i]);

        apply("sw_10", mk(I_SW, 0, 8, 32'hDEADBEEF, 8,
                          0, 2'b00, 1, 32'h10, 0, 0, 0, 0));
        apply("lw_10", mk(I_LW, 0, 32'h10, 0, 0,
                          1, 2'b00, 0, 0, 1, 32'hDEADBEEF, 0, 0));
`ifdef SUBWORD_MEM_EN
        apply("lb_13", mk(I_LB, 0, 32'h13, 0, 0,
                          1, 2'b00, 0, 0, 1, 32'hFFFFFFDE, 0, 0));
`else
        apply("lb_13", mk(I_LB, 0, 32'h13, 0, 0,
                          1, 2'b00, 0, 0, 1, 32'hDEADBEEF, 0, 0));
`endif
        apply("sw_wrap", mk(I_SW, 0, 32'h400, 32'hCAFEF00D, 32'h10,
                            0, 2'b00, 1, 32'h410, 0, 0, 0, 0));
        apply("lw_wrap", mk(I_LW, 0, 32'h10, 0, 0,
                            1, 2'b00, 0, 0, 1, 32'hCAFEF00D, 0, 0));

        apply("sw_20", mk(I_SW, 0, 32'h20, 32'h0BADF00D, 0,
                          0, 2'b00, 0, 0, 0, 0, 0, 0));
        apply("lw_20", mk(I_LW, 0, 32'h20, 0, 0,
                          1, 2'b00, 0, 0, 1, 32'h0BADF00D, 0, 0));
        #1 rst_n = 1'b0;
        #1 chk("lw_20_in_reset", wb_data, 32'd0);
        #1 rst_n = 1'b1;
        #1 chk("lw_20_after_reset", wb_data, 32'd0);

        @(negedge clk);
        rst_n    = 1'b0;
        instr    = I_SW;
        rs1_data = 32'h24;
        rs2_data = 32'h12345678;
        imm      = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        apply("lw_24_blocked", mk(I_LW, 0, 32'h24, 0, 0,
                                  1, 2'b00, 0, 0, 1, 32'd0, 0, 0));

        apply("op_7f", mk(32'h0000007F, 0, 32'h30, 32'hAAAA5555, 0,
                          0, 2'b00, 0, 0, 0, 0, 0, 0));
        apply("lw_30", mk(I_LW, 0, 32'h30, 0, 0,
                          1, 2'b00, 0, 0, 1, 32'd0, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
